hdpldadapt_rx_datapath_cp_align: RTL and testbench
==================================================

// Module: hdpldadapt_rx_datapath_cp_align
// PURPOSE
//  RX-direction channel-bonding control plane for the read-FIFO read enable: receives the bonded
//  rden token from the master or from the up/down chain, relays it to neighbours with one register
//  per hop, and delays the local copy by a programmed compensation count so every bonded channel
//  reads on the same cycle. An alignment FSM gates the local enable until the first token is aligned
//  and flags misconfiguration or a missing token. Sits in the RX channel next to the read FIFO.
// PARAMETERS
//  CNTWIDTH  4  width of r_comp_cnt; delay line depth MAXDLY = 2**CNTWIDTH
//  TOWIDTH   8  width of WAIT-state timeout counter; timeout at 2**TOWIDTH-1 enabled cycles
// PORTS
//  rx_rdfifo_clk          in   1         RX read-FIFO clock; sole clock
//  rx_rdfifo_clk_rst      in   1         asynchronous, active-high reset
//  rd_srst_n              in   1         synchronous reset, active-low
//  data_enable            in   1         stall qualifier; 0 = all state holds
//  r_us_master            in   1         this channel drives master token onto up chain
//  r_ds_master            in   1         this channel drives master token onto down chain
//  r_compin_sel           in   2         0 master_in, 1 us_in, 2 ds_in, 3 disabled
//  r_comp_cnt             in   CNTWIDTH  compensation delay c
//  r_double_rd            in   1         double-rate read: delay = 2c
//  r_bonding_dft_in_en    in   1         force chain inputs during scan
//  r_bonding_dft_in_value in   1         forced chain input value
//  master_in_rden         in   1         local master rden token
//  us_in_rden / ds_in_rden in  1         tokens arriving from up / down neighbour
//  us_out_rden / ds_out_rden out 1       registered tokens to up / down neighbour
//  comp_out_rden_en       out  1         aligned local read enable
//  align_done             out  1         FSM in ALIGNED
//  align_err              out  1         FSM in ERR (sticky)
//  rx_cp_align_testbus    out  16        debug
// BEHAVIOUR
//  - Async reset or rd_srst_n=0: all regs 0, FSM IDLE; every output 0. srst overrides data_enable.
//  - DFT: us_in_int/ds_in_int = r_bonding_dft_in_en ? r_bonding_dft_in_value : us_in/ds_in.
//  - Relay (1 cycle, when data_enable): us_out <= r_us_master ? master_in : ds_in_int;
//    ds_out <= r_ds_master ? master_in : us_in_int.
//  - compin = mux(r_compin_sel); sel 3 -> 0. Delay d = r_double_rd ? min(2c, MAXDLY-1) : c
//    (compute 2c in CNTWIDTH+1 bits, then saturate).
//  - Shift reg sr[MAXDLY-1:0]: sr[0]<=compin, sr[i]<=sr[i-1] when data_enable. Tap = sr[d].
//  - comp_out_rden_en = (state==ALIGNED) ? sr[d] : 0; total latency compin->output = d+1 enabled cycles.
//  - FSM (advances only when data_enable):
//    IDLE: r_compin_sel!=3 -> WAIT (tocnt=0).
//    WAIT: compin rising (compin=1, prev=0) -> d==0 ? ALIGNED : COUNT with cnt=0;
//          else tocnt++; tocnt==2**TOWIDTH-1 -> ERR.
//    COUNT: cnt==d-1 -> ALIGNED, else cnt++. First comp_out pulse coincides with align_done rising,
//          exactly d+1 cycles after the edge cycle.
//    ALIGNED: hold. r_compin_sel==3 in any non-ERR state -> IDLE.
//    Config change (r_comp_cnt, r_compin_sel to 0..2, r_double_rd differs from value latched on
//    IDLE->WAIT) in WAIT/COUNT/ALIGNED -> ERR. ERR exits only via rd_srst_n or reset.
//  - Rising-edge detector prev reg updates with data_enable; reset 0 (token high at exit of IDLE
//    is not an edge).
//  - testbus = {state[2:0], cnt[3:0], compin, sr[d], prev, us_in_int, ds_in_int, master_in_rden,
//    data_enable, align_done, align_err}.
// TESTING
//  1. sel=0, c=3, master_in pulse at cycle 10 -> align_done and comp_out both rise at cycle 14; 
//     us_out/ds_out per master bits at 11.
//  2. c=9, r_double_rd=1 -> d=15 (saturated from 18); first comp_out 16 cycles after edge.
//  3. c=0, sel=1, us_in pulse -> ALIGNED next cycle, comp_out high same cycle.
//  4. data_enable low 5 cycles mid-COUNT -> cnt/sr hold; alignment delayed by exactly 5 cycles.
//  5. No token for 255 enabled cycles in WAIT -> align_err=1, comp_out stays 0; rd_srst_n pulse -> IDLE.
//  6. Change r_comp_cnt in ALIGNED -> ERR; DFT en=1,value=1 -> us_out=ds_out=1 next cycle (non-master).

Source files
------------

// File: rtl/hdpldadapt_rx_datapath_cp_align.sv
// Bonded RX read-enable control plane: relays the rden token one hop per register and delays the local copy.
// Latency: relay 1 cycle; local enable d+1 enabled cycles after the token edge (d = programmed compensation).
// Backpressure: none; data_enable low freezes every register, rd_srst_n low clears regardless of data_enable.
module hdpldadapt_rx_datapath_cp_align #(
  parameter int CNTWIDTH = 4,
  parameter int TOWIDTH  = 8
) (
  input  logic                rx_rdfifo_clk,
  input  logic                rx_rdfifo_clk_rst,
  input  logic                rd_srst_n,
  input  logic                data_enable,
  input  logic                r_us_master,
  input  logic                r_ds_master,
  input  logic [1:0]          r_compin_sel,
  input  logic [CNTWIDTH-1:0] r_comp_cnt,
  input  logic                r_double_rd,
  input  logic                r_bonding_dft_in_en,
  input  logic                r_bonding_dft_in_value,
  input  logic                master_in_rden,
  input  logic                us_in_rden,
  input  logic                ds_in_rden,
  output logic                us_out_rden,
  output logic                ds_out_rden,
  output logic                comp_out_rden_en,
  output logic                align_done,
  output logic                align_err,
  output logic [15:0]         rx_cp_align_testbus
);

  localparam int MAXDLY = 2**CNTWIDTH;
  localparam logic [TOWIDTH-1:0]  TO_LAST = {{(TOWIDTH-1){1'b1}}, 1'b0};
  localparam logic [CNTWIDTH:0]   ONE_W   = 1;
  localparam logic [CNTWIDTH-1:0] CNT_ONE = 1;
  localparam logic [TOWIDTH-1:0]  TO_ONE  = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_COUNT   = 3'd2,
    ST_ALIGNED = 3'd3,
    ST_ERR     = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [MAXDLY-1:0]   r_sr;
  logic                r_prev;
  logic [CNTWIDTH-1:0] r_cnt;
  logic [CNTWIDTH-1:0] w_cnt_nxt;
  logic [TOWIDTH-1:0]  r_tocnt;
  logic [TOWIDTH-1:0]  w_tocnt_nxt;
  logic                r_us_out;
  logic                r_ds_out;
  logic [CNTWIDTH-1:0] r_lat_cnt;
  logic [1:0]          r_lat_sel;
  logic                r_lat_dbl;
  logic                w_latch;

  logic                w_us_in_int;
  logic                w_ds_in_int;
  logic                w_compin;
  logic [CNTWIDTH:0]   w_dbl;
  logic [CNTWIDTH-1:0] w_dly;
  logic                w_tap;
  logic                w_edge;
  logic                w_cfg_chg;

  assign w_us_in_int = r_bonding_dft_in_en ? r_bonding_dft_in_value : us_in_rden;
  assign w_ds_in_int = r_bonding_dft_in_en ? r_bonding_dft_in_value : ds_in_rden;

  always_comb begin
    w_compin = 1'b0;
    case (r_compin_sel)
      2'd0:    w_compin = master_in_rden;
      2'd1:    w_compin = w_us_in_int;
      2'd2:    w_compin = w_ds_in_int;
      default: w_compin = 1'b0;
    endcase
  end

  // Doubled delay is formed one bit wider so an overflow saturates to the last tap.
  assign w_dbl     = {r_comp_cnt, 1'b0};
  assign w_dly     = !r_double_rd ? r_comp_cnt :
                     (w_dbl[CNTWIDTH] ? {CNTWIDTH{1'b1}} : w_dbl[CNTWIDTH-1:0]);
  assign w_tap     = r_sr[w_dly];
  assign w_edge    = w_compin & ~r_prev;
  assign w_cfg_chg = (r_comp_cnt != r_lat_cnt) || (r_compin_sel != r_lat_sel) ||
                     (r_double_rd != r_lat_dbl);

  always_ff @(posedge rx_rdfifo_clk or posedge rx_rdfifo_clk_rst) begin
    if (rx_rdfifo_clk_rst) begin
      r_state <= ST_IDLE;
    end else if (!rd_srst_n) begin
      r_state <= ST_IDLE;
    end else if (data_enable) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tocnt_nxt = r_tocnt;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_compin_sel != 2'd3) begin
          w_state_nxt = ST_WAIT;
          w_tocnt_nxt = '0;
          w_latch     = 1'b1;
        end
      end
      ST_WAIT, ST_COUNT, ST_ALIGNED: begin
        // Disable wins over a config change so software can park a channel cleanly.
        if (r_compin_sel == 2'd3) begin
          w_state_nxt = ST_IDLE;
        end else if (w_cfg_chg) begin
          w_state_nxt = ST_ERR;
        end else if (r_state == ST_WAIT) begin
          if (w_edge) begin
            w_state_nxt = (w_dly == '0) ? ST_ALIGNED : ST_COUNT;
            w_cnt_nxt   = '0;
          end else if (r_tocnt == TO_LAST) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_tocnt_nxt = r_tocnt + TO_ONE;
          end
        end else if (r_state == ST_COUNT) begin
          if (({1'b0, r_cnt} + ONE_W) == {1'b0, w_dly}) begin
            w_state_nxt = ST_ALIGNED;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end
      ST_ERR:  w_state_nxt = ST_ERR;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge rx_rdfifo_clk or posedge rx_rdfifo_clk_rst) begin
    if (rx_rdfifo_clk_rst) begin
      r_sr      <= '0;
      r_prev    <= 1'b0;
      r_cnt     <= '0;
      r_tocnt   <= '0;
      r_us_out  <= 1'b0;
      r_ds_out  <= 1'b0;
      r_lat_cnt <= '0;
      r_lat_sel <= '0;
      r_lat_dbl <= 1'b0;
    end else if (!rd_srst_n) begin
      r_sr      <= '0;
      r_prev    <= 1'b0;
      r_cnt     <= '0;
      r_tocnt   <= '0;
      r_us_out  <= 1'b0;
      r_ds_out  <= 1'b0;
      r_lat_cnt <= '0;
      r_lat_sel <= '0;
      r_lat_dbl <= 1'b0;
    end else if (data_enable) begin
      r_sr     <= {r_sr[MAXDLY-2:0], w_compin};
      r_prev   <= w_compin;
      r_cnt    <= w_cnt_nxt;
      r_tocnt  <= w_tocnt_nxt;
      r_us_out <= r_us_master ? master_in_rden : w_ds_in_int;
      r_ds_out <= r_ds_master ? master_in_rden : w_us_in_int;
      if (w_latch) begin
        r_lat_cnt <= r_comp_cnt;
        r_lat_sel <= r_compin_sel;
        r_lat_dbl <= r_double_rd;
      end
    end
  end

  always_comb begin
    align_done       = (r_state == ST_ALIGNED);
    align_err        = (r_state == ST_ERR);
    comp_out_rden_en = (r_state == ST_ALIGNED) ? w_tap : 1'b0;
  end

  assign us_out_rden = r_us_out;
  assign ds_out_rden = r_ds_out;

  assign rx_cp_align_testbus = {r_state, 4'(r_cnt), w_compin, w_tap, r_prev, w_us_in_int,
                                w_ds_in_int, master_in_rden, data_enable, align_done, align_err};

endmodule

// File: tb/tb_hdpldadapt_rx_datapath_cp_align.sv
// Bench for the RX rden alignment block: directed scenarios with literal expectations, then a randomized
// run compared every cycle against a history-queue model of the token path and alignment rules.
module tb_hdpldadapt_rx_datapath_cp_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        srst_n, de, usm, dsm, dbl, dften, dftval, mst, usin, dsin;
  logic [1:0]  sel;
  logic [3:0]  cc;
  logic        us_out, ds_out, comp_out, done, err;
  logic [15:0] tbus;

  hdpldadapt_rx_datapath_cp_align dut (
    .rx_rdfifo_clk         (clk),
    .rx_rdfifo_clk_rst     (rst),
    .rd_srst_n             (srst_n),
    .data_enable           (de),
    .r_us_master           (usm),
    .r_ds_master           (dsm),
    .r_compin_sel          (sel),
    .r_comp_cnt            (cc),
    .r_double_rd           (dbl),
    .r_bonding_dft_in_en   (dften),
    .r_bonding_dft_in_value(dftval),
    .master_in_rden        (mst),
    .us_in_rden            (usin),
    .ds_in_rden            (dsin),
    .us_out_rden           (us_out),
    .ds_out_rden           (ds_out),
    .comp_out_rden_en      (comp_out),
    .align_done            (done),
    .align_err             (err),
    .rx_cp_align_testbus   (tbus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 waiting for token, 2 counting since edge, 3 aligned, 4 error.
  int m_mode, m_age, m_nedge, l_cc, l_sel;
  bit l_dbl, m_prev, m_us, m_ds;
  bit m_hist[$];

  function automatic int f_dly(input int c, input bit db);
    if (!db) return c;
    return (2 * c > 15) ? 15 : 2 * c;
  endfunction

  function automatic bit f_compin();
    bit ui, di;
    ui = dften ? dftval : usin;
    di = dften ? dftval : dsin;
    case (sel)
      2'd0:    return mst;
      2'd1:    return ui;
      2'd2:    return di;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_clear();
    m_mode = 0; m_age = 0; m_nedge = 0; m_prev = 0; m_us = 0; m_ds = 0;
    l_cc = 0; l_sel = 0; l_dbl = 0;
    m_hist = {};
    for (int i = 0; i < 16; i++) m_hist.push_back(1'b0);
  endtask

  task automatic m_step();
    bit ci, ed, chg;
    int d;
    ci  = f_compin();
    ed  = ci && !m_prev;
    d   = f_dly(int'(cc), dbl);
    chg = (int'(cc) != l_cc) || (int'(sel) != l_sel) || (dbl != l_dbl);
    if (m_mode == 0) begin
      if (sel != 2'd3) begin
        m_mode = 1; m_nedge = 0; l_cc = int'(cc); l_sel = int'(sel); l_dbl = dbl;
      end
    end else if (m_mode != 4) begin
      if (sel == 2'd3) m_mode = 0;
      else if (chg) m_mode = 4;
      else if (m_mode == 1) begin
        if (ed) begin
          if (d == 0) m_mode = 3;
          else begin m_mode = 2; m_age = 1; end
        end else begin
          m_nedge++;
          if (m_nedge == 255) m_mode = 4;
        end
      end else if (m_mode == 2) begin
        m_age++;
        if (m_age == d + 1) m_mode = 3;
      end
    end
    m_hist.push_front(ci);
    void'(m_hist.pop_back());
    m_prev = ci;
    m_us   = usm ? mst : (dften ? dftval : dsin);
    m_ds   = dsm ? mst : (dften ? dftval : usin);
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_clear();
      else if (!srst_n) m_clear();
      else if (de) m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        int d;
        bit ec;
        d  = f_dly(int'(cc), dbl);
        ec = (m_mode == 3) ? m_hist[d] : 1'b0;
        chk("align_done", done, (m_mode == 3));
        chk("align_err", err, (m_mode == 4));
        chk("comp_out", comp_out, ec);
        chk("us_out", us_out, m_us);
        chk("ds_out", ds_out, m_ds);
        chk("tbus_flags", tbus[1:0], {(m_mode == 3), (m_mode == 4)});
        chk("tbus_tap_prev", tbus[7:6], {m_hist[d], m_prev});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_srst();
    srst_n = 1'b0;
    step(1);
    srst_n = 1'b1;
  endtask

  initial begin
    rst = 1'b1; srst_n = 1'b1; de = 1'b1; usm = 1'b0; dsm = 1'b0; sel = 2'd3; cc = 4'd0;
    dbl = 1'b0; dften = 1'b0; dftval = 1'b0; mst = 1'b0; usin = 1'b0; dsin = 1'b0;
    step(3);
    chk("rst_outs", {us_out, ds_out, comp_out, done, err}, 5'b0);
    chk("rst_tbus", tbus[15:3], 13'h0);
    rst = 1'b0;

    // Basic alignment, c=3.
    sel = 2'd0; cc = 4'd3; usm = 1'b1; dsm = 1'b1;
    step(3);
    mst = 1'b1; step(1); mst = 1'b0;
    chk("t1_relay", {us_out, ds_out}, 2'b11);
    chk("t1_done_early", done, 1'b0);
    step(2); chk("t1_done_d", done, 1'b0);
    step(1); chk("t1_align", {done, comp_out}, 2'b11);
    step(1); chk("t1_pulse_end", {done, comp_out}, 2'b10);

    // Double rate, saturated delay 15.
    srst_n = 1'b0; cc = 4'd9; dbl = 1'b1; step(1); srst_n = 1'b1;
    step(2);
    mst = 1'b1; step(1); mst = 1'b0;
    step(14); chk("t2_not_yet", {done, comp_out}, 2'b00);
    step(1);  chk("t2_align", {done, comp_out}, 2'b11);

    // Zero delay from the up chain.
    srst_n = 1'b0; cc = 4'd0; dbl = 1'b0; sel = 2'd1; step(1); srst_n = 1'b1;
    step(2);
    usin = 1'b1; step(1); usin = 1'b0;
    chk("t3_align", {done, comp_out}, 2'b11);
    step(1); chk("t3_after", comp_out, 1'b0);

    // Stall mid-count.
    srst_n = 1'b0; cc = 4'd3; sel = 2'd0; step(1); srst_n = 1'b1;
    step(2);
    mst = 1'b1; step(1); mst = 1'b0;
    step(1);
    de = 1'b0; step(5); chk("t4_stalled", done, 1'b0);
    de = 1'b1; step(1); chk("t4_not_yet", done, 1'b0);
    step(1); chk("t4_align", {done, comp_out}, 2'b11);

    // Timeout in WAIT.
    do_srst();
    step(1);
    step(254); chk("t5_pre_to", err, 1'b0);
    step(1);   chk("t5_to", {err, comp_out}, 2'b10);
    do_srst(); chk("t5_clear", {err, done}, 2'b00);

    // Config change in ALIGNED, then DFT forcing.
    srst_n = 1'b0; cc = 4'd2; usm = 1'b0; dsm = 1'b0; step(1); srst_n = 1'b1;
    step(2);
    mst = 1'b1; step(1); mst = 1'b0;
    step(3); chk("t6_aligned", done, 1'b1);
    cc = 4'd5; step(1); chk("t6_err", {err, done}, 2'b10);
    dften = 1'b1; dftval = 1'b1; usin = 1'b0; dsin = 1'b0;
    step(1); chk("t6_dft", {us_out, ds_out}, 2'b11);
    dften = 1'b0;

    // Randomized traffic with occasional reconfiguration.
    for (int i = 0; i < 6000; i++) begin
      de    = ($urandom_range(0, 9) != 0);
      mst   = ($urandom_range(0, 11) == 0);
      usin  = ($urandom_range(0, 11) == 0);
      dsin  = ($urandom_range(0, 11) == 0);
      dften = ($urandom_range(0, 49) == 0);
      dftval = 1'($urandom_range(0, 1));
      srst_n = 1'b1;
      if ($urandom_range(0, 119) == 0) begin
        srst_n = 1'b0;
        sel = 2'($urandom_range(0, 3)); cc = 4'($urandom_range(0, 15));
        dbl = 1'($urandom_range(0, 1)); usm = 1'($urandom_range(0, 1));
        dsm = 1'($urandom_range(0, 1));
      end else if ($urandom_range(0, 399) == 0) begin
        sel = 2'($urandom_range(0, 3)); cc = 4'($urandom_range(0, 15));
      end
      if (i == 3000) rst = 1'b1;
      step(1);
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
